// File: rtl/mem_arbiter.sv
// Three-port arbiter/sequencer in front of the SRAM controller request port.
// Video has absolute priority; CPU and DMA alternate when both are waiting.
module mem_arbiter #(
    parameter int unsigned ACC_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        vid_req,
    input  logic [19:0] vid_addr,
    output logic [15:0] vid_rdata,
    output logic        vid_ack,
    input  logic        cpu_req,
    input  logic [19:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_wb,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic [19:0] dma_addr,
    input  logic [15:0] dma_wdata,
    input  logic        dma_we,
    input  logic        dma_wb,
    output logic [15:0] dma_rdata,
    output logic        dma_ack,
    output logic [19:0] addr_data,
    output logic [15:0] wr_data,
    output logic        we,
    output logic        w_b,
    input  logic [15:0] rd_data,
    output logic        busy
);

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    localparam logic [1:0] GNT_VID = 2'd0;
    localparam logic [1:0] GNT_CPU = 2'd1;
    localparam logic [1:0] GNT_DMA = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     gnt_q, gnt_d;
    logic           last_q, last_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic           we_q, we_d;
    logic           wb_q, wb_d;
    logic [DW-1:0]  vid_rdata_q, vid_rdata_d;
    logic [DW-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]  dma_rdata_q, dma_rdata_d;
    logic           vid_ack_q, vid_ack_d;
    logic           cpu_ack_q, cpu_ack_d;
    logic           dma_ack_q, dma_ack_d;
    logic           busy_q, busy_d;

    // Next-state, grant selection and controller-side register updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        wb_d        = wb_q;
        vid_rdata_d = vid_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        vid_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (vid_req || cpu_req || dma_req) begin
                    state_d = BUSY;
                    cnt_d   = CW'(ACC_CYC - 1);
                    if (vid_req) begin
                        gnt_d   = GNT_VID;
                        addr_d  = vid_addr;
                        wdata_d = '0;
                        we_d    = 1'b1;
                        wb_d    = 1'b0;
                    end else if (cpu_req && (!dma_req || last_q)) begin
                        // last_q == 1 means DMA was served last, so CPU wins the tie
                        gnt_d   = GNT_CPU;
                        last_d  = 1'b0;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        we_d    = cpu_we;
                        wb_d    = cpu_wb;
                    end else begin
                        gnt_d   = GNT_DMA;
                        last_d  = 1'b1;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                        we_d    = dma_we;
                        wb_d    = dma_wb;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                    we_d    = 1'b1;
                    if (gnt_q == GNT_VID) begin
                        vid_ack_d = 1'b1;
                        if (we_q) vid_rdata_d = rd_data;
                    end else if (gnt_q == GNT_CPU) begin
                        cpu_ack_d = 1'b1;
                        if (we_q) cpu_rdata_d = rd_data;
                    end else begin
                        dma_ack_d = 1'b1;
                        if (we_q) dma_rdata_d = rd_data;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_q       <= GNT_VID;
            last_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b1;
            wb_q        <= 1'b0;
            vid_rdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            wb_q        <= wb_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            vid_ack_q   <= vid_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign addr_data = addr_q;
    assign wr_data   = wdata_q;
    assign we        = we_q;
    assign w_b       = wb_q;
    assign vid_rdata = vid_rdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign vid_ack   = vid_ack_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign busy      = busy_q;

endmodule
